// File: rtl/conv_array_stream.sv
// Stream-fed KxK signed convolution engine with line buffers,
// coefficient loader, drain sequencer and rounded/saturated output.
module conv_array_stream #(
    parameter int K     = 3,
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int AW    = 2*DW + $clog2(K*K),
    parameter int SHW   = 4
) (
    input  logic           clk,
    input  logic           nRST,
    input  logic           cfg_load,
    input  logic           filt_valid,
    output logic           filt_ready,
    input  logic [DW-1:0]  filt_data,
    input  logic           pix_valid,
    output logic           pix_ready,
    input  logic [DW-1:0]  pix_data,
    input  logic           pix_sof,
    input  logic [SHW-1:0] shift,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic           out_sat,
    output logic           busy
);

    localparam int NC = K*K;
    localparam int FW = $clog2(NC);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = $clog2(K);
    localparam int ND = K-1;

    localparam logic signed [AW:0] MAXV = {{(AW+2-DW){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW:0] MINV = {{(AW+2-DW){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_FILT,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e state_q, state_d;

    logic                 live_q;
    logic                 busy_q;
    logic [FW-1:0]        fcnt_q;
    logic signed [DW-1:0] coef_q [NC];
    logic signed [DW-1:0] win_q  [NC];
    logic [DW-1:0]        lb_q   [K-1][IMG_W];
    logic [CW-1:0]        c_q;
    logic [RW-1:0]        r_q;
    logic                 fv_q;
    logic                 v1_q;
    logic [ND-1:0]        av_q;
    logic signed [AW-1:0] acc_q  [ND];
    logic                 out_valid_q;
    logic                 out_sat_q;
    logic [DW-1:0]        out_data_q;

    logic                   adv;
    logic                   filt_fire;
    logic                   pix_fire;
    logic                   last_coef;
    logic                   pipe_empty;
    logic [CW-1:0]          pos_c;
    logic [RW-1:0]          pos_r;
    logic                   fv_c;
    logic                   res_c;
    logic [DW-1:0]          colv   [K];
    logic signed [2*DW-1:0] prod_c [NC];
    logic signed [AW-1:0]   sum_c;
    logic signed [AW:0]     ext_c;
    logic signed [AW:0]     rnd_c;
    logic signed [AW:0]     shd_c;
    logic [DW-1:0]          od_c;
    logic                   of_c;

    assign adv        = !(out_valid_q && !out_ready);
    assign filt_fire  = filt_valid && filt_ready;
    assign pix_fire   = pix_valid && pix_ready;
    assign last_coef  = fcnt_q == FW'(NC-1);
    assign pipe_empty = !v1_q && (av_q == '0) && !out_valid_q;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q <= S_FILT;
            live_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            busy_q  <= state_q != S_FILT;
        end
    end

    always_comb begin
        state_d    = state_q;
        filt_ready = 1'b0;
        pix_ready  = 1'b0;
        unique case (state_q)
            S_FILT: begin
                filt_ready = live_q;
                if (filt_valid && live_q && last_coef) state_d = S_RUN;
            end
            S_RUN: begin
                pix_ready = adv;
                if (cfg_load) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pipe_empty) state_d = S_FILT;
            end
            default: state_d = S_FILT;
        endcase
    end

    // A start-of-frame beat is placed at (0,0) before anything else looks at it
    always_comb begin
        pos_c = pix_sof ? '0 : c_q;
        pos_r = pix_sof ? '0 : r_q;
        fv_c  = pix_sof || fv_q;
        res_c = pix_fire && fv_c && (pos_r == RW'(K-1)) && (pos_c >= CW'(K-1));
        colv[K-1] = pix_data;
        for (int i = 0; i < K-1; i++) colv[i] = lb_q[K-2-i][pos_c];
    end

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < NC; k++) begin
            prod_c[k] = (2*DW)'(win_q[k]) * (2*DW)'(coef_q[k]);
            sum_c     = sum_c + AW'(prod_c[k]);
        end
    end

    always_comb begin
        ext_c = (AW+1)'(acc_q[ND-1]);
        rnd_c = ext_c;
        if (shift != '0) rnd_c = ext_c + (ONE << (shift - SHW'(1)));
        shd_c = rnd_c >>> shift;
        od_c  = shd_c[DW-1:0];
        of_c  = 1'b0;
        if (shd_c > MAXV) begin
            od_c = {1'b0, {(DW-1){1'b1}}};
            of_c = 1'b1;
        end else if (shd_c < MINV) begin
            od_c = {1'b1, {(DW-1){1'b0}}};
            of_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            fcnt_q      <= '0;
            c_q         <= '0;
            r_q         <= '0;
            fv_q        <= 1'b0;
            v1_q        <= 1'b0;
            av_q        <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < NC; k++) begin
                coef_q[k] <= '0;
                win_q[k]  <= '0;
            end
            for (int k = 0; k < K-1; k++)
                for (int c = 0; c < IMG_W; c++) lb_q[k][c] <= '0;
            for (int k = 0; k < ND; k++) acc_q[k] <= '0;
        end else begin
            if (filt_fire) begin
                coef_q[fcnt_q] <= filt_data;
                fcnt_q         <= last_coef ? '0 : fcnt_q + 1'b1;
            end
            if (pix_fire) begin
                c_q  <= (pos_c == CW'(IMG_W-1)) ? '0 : pos_c + 1'b1;
                r_q  <= pos_r;
                fv_q <= fv_c;
                if (pos_c == CW'(IMG_W-1) && pos_r != RW'(K-1)) r_q <= pos_r + 1'b1;
                lb_q[0][pos_c] <= pix_data;
                for (int k = 1; k < K-1; k++) lb_q[k][pos_c] <= lb_q[k-1][pos_c];
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K-1; j++) win_q[i*K+j] <= win_q[i*K+j+1];
                    win_q[i*K+K-1] <= colv[i];
                end
            end else if (state_q != S_RUN) begin
                fv_q <= 1'b0;
            end
            // Whole pipeline freezes while a result waits on the consumer
            if (adv) begin
                v1_q     <= res_c;
                av_q[0]  <= v1_q;
                acc_q[0] <= sum_c;
                for (int k = ND-1; k > 0; k--) begin
                    av_q[k]  <= av_q[k-1];
                    acc_q[k] <= acc_q[k-1];
                end
                out_valid_q <= av_q[ND-1];
                if (av_q[ND-1]) begin
                    out_data_q <= od_c;
                    out_sat_q  <= of_c;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_conv_array_stream.sv
// Bench for conv_array_stream: directed frames checked against a
// formula-level convolution model plus pinned literal results.
module tb_conv_array_stream;

    localparam int K     = 3;
    localparam int DW    = 8;
    localparam int IMG_W = 8;
    localparam int SHW   = 4;
    localparam int NC    = K*K;

    logic           clk = 1'b0;
    logic           nRST = 1'b0;
    logic           cfg_load = 1'b0;
    logic           filt_valid = 1'b0;
    logic           filt_ready;
    logic [DW-1:0]  filt_data = '0;
    logic           pix_valid = 1'b0;
    logic           pix_ready;
    logic [DW-1:0]  pix_data = '0;
    logic           pix_sof = 1'b0;
    logic [SHW-1:0] shift = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [DW-1:0]  out_data;
    logic           out_sat;
    logic           busy;

    always #5 clk = ~clk;

    conv_array_stream #(.K(K), .DW(DW), .IMG_W(IMG_W), .SHW(SHW)) dut (
        .clk(clk), .nRST(nRST), .cfg_load(cfg_load),
        .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sof(pix_sof), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    int     n_chk = 0;
    int     n_fail = 0;
    longint cyc = 0;

    int  mcoef [NC];
    int  img [K][IMG_W];
    int  mfc = 0, mr = 0, mc = 0;
    bit  mrun = 0, mfv = 0;
    int  exp_d [$];
    bit  exp_s [$];
    int  got_d [$];
    bit  got_s [$];
    longint t_acc1 = -1, t_val1 = -1;
    int  stall_seen = 0;
    bit  prev_stall = 0;
    int  prev_d = 0;
    bit  prev_s = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    function automatic void rnd_sat(input longint y, input int s,
                                    output int d, output bit f);
        longint t;
        t = y;
        if (s > 0) t = (y + (longint'(1) <<< (s-1))) >>> s;
        if (t > 127) begin d = 127; f = 1; end
        else if (t < -128) begin d = -128; f = 1; end
        else begin d = int'(t); f = 0; end
    endfunction

    function automatic longint gd(input int i);
        if (i < got_d.size()) return got_d[i];
        return -999;
    endfunction

    function automatic longint gs(input int i);
        if (i < got_s.size()) return got_s[i];
        return -999;
    endfunction

    task automatic model_pix();
        int pr, pc, d;
        bit f;
        longint y;
        if (pix_sof) begin pr = 0; pc = 0; mfv = 1; end
        else begin pr = mr; pc = mc; end
        if (mfv) begin
            img[pr % K][pc] = $signed(pix_data);
            if (pr >= K-1 && pc >= K-1) begin
                y = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        y += mcoef[i*K+j] * img[(pr-K+1+i) % K][pc-K+1+j];
                rnd_sat(y, int'(shift), d, f);
                exp_d.push_back(d);
                exp_s.push_back(f);
                if (t_acc1 < 0) t_acc1 = cyc;
            end
        end
        pc++;
        if (pc == IMG_W) begin pc = 0; pr++; end
        mr = pr;
        mc = pc;
    endtask

    always @(negedge clk) begin
        if (!nRST) begin
            mfc = 0; mrun = 0; mfv = 0; prev_stall = 0;
            exp_d.delete();
            exp_s.delete();
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", $signed(out_data), prev_d);
                check("stall_sat", out_sat, prev_s);
            end
            if (out_valid && t_val1 < 0) t_val1 = cyc;
            if (out_valid && out_ready) begin
                got_d.push_back($signed(out_data));
                got_s.push_back(out_sat);
                if (exp_d.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %0d expected no result",
                             $signed(out_data));
                end else begin
                    check("out_data", $signed(out_data), exp_d.pop_front());
                    check("out_sat", out_sat, exp_s.pop_front());
                end
            end
            if (out_valid && !out_ready) begin
                check("pix_ready_stall", pix_ready, 0);
                stall_seen++;
            end
            if (!mrun) check("pix_ready_idle", pix_ready, 0);
            prev_stall = out_valid && !out_ready;
            prev_d = $signed(out_data);
            prev_s = out_sat;
            if (filt_valid && filt_ready) begin
                mcoef[mfc] = $signed(filt_data);
                mfc++;
                if (mfc == NC) begin mfc = 0; mrun = 1; end
            end
            if (pix_valid && pix_ready) model_pix();
            if (cfg_load && mrun) begin mrun = 0; mfv = 0; end
        end
    end

    task automatic send_filt(input int v);
        int n = 0;
        filt_valid = 1'b1;
        filt_data  = v[DW-1:0];
        @(negedge clk);
        while (!filt_ready && n < 300) begin @(negedge clk); n++; end
        if (!filt_ready) check("filt_timeout", 0, 1);
        @(posedge clk); #1;
        filt_valid = 1'b0;
    endtask

    task automatic load_filter(input int f [NC]);
        for (int k = 0; k < NC; k++) send_filt(f[k]);
    endtask

    task automatic send_pix(input int v, input bit sof, input bit cl);
        int n = 0;
        pix_valid = 1'b1;
        pix_data  = v[DW-1:0];
        pix_sof   = sof;
        cfg_load  = cl;
        @(negedge clk);
        while (!pix_ready && n < 300) begin @(negedge clk); n++; end
        if (!pix_ready) check("pix_timeout", 0, 1);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        cfg_load  = 1'b0;
    endtask

    function automatic int pixv(input int pat, input int r, input int c);
        if (pat == 0) return 8*r + c;
        if (pat == 1) return 127;
        return ((r*37 + c*59 + 11) % 256) - 128;
    endfunction

    task automatic send_frame(input int pat, input int rows, input int roff);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < IMG_W; c++)
                send_pix(pixv(pat, r+roff, c), r == 0 && c == 0, 1'b0);
    endtask

    task automatic wait_filt();
        int n = 0;
        @(negedge clk);
        while (!filt_ready && n < 300) begin @(negedge clk); n++; end
        if (!filt_ready) check("filt_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic cfg_pulse();
        cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        wait_filt();
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((exp_d.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic start_phase();
        got_d.delete();
        got_s.delete();
        t_acc1 = -1;
        t_val1 = -1;
        stall_seen = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_filt_ready"}, filt_ready, 0);
        check({tag, "_pix_ready"}, pix_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_sat"}, out_sat, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk); #1;
        nRST = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_filt_ready", filt_ready, 1);
        check("post_rst_busy", busy, 0);
        @(posedge clk); #1;

        // identity filter
        shift = 0;
        load_filter('{0, 0, 0, 0, 1, 0, 0, 0, 0});
        start_phase();
        send_frame(0, 5, 0);
        wait_idle();
        check("id_count", got_d.size(), 18);
        check("id_first", gd(0), 9);
        check("id_last", gd(17), 30);
        check("id_latency", t_val1 - t_acc1, 4);
        check("run_busy", busy, 1);

        // positive saturation, then rounding shift
        cfg_pulse();
        load_filter('{1, 1, 1, 1, 1, 1, 1, 1, 1});
        start_phase();
        send_frame(1, 3, 0);
        wait_idle();
        check("psat_count", got_d.size(), 6);
        check("psat_data", gd(0), 127);
        check("psat_flag", gs(0), 1);
        shift = 4;
        start_phase();
        send_frame(1, 3, 0);
        wait_idle();
        check("shift4_data", gd(0), 71);
        check("shift4_flag", gs(0), 0);

        // negative saturation
        cfg_pulse();
        shift = 0;
        load_filter('{-128, -128, -128, -128, -128, -128, -128, -128, -128});
        start_phase();
        send_frame(1, 3, 0);
        wait_idle();
        check("nsat_data", gd(0), -128);
        check("nsat_flag", gs(0), 1);

        // mixed filter with backpressure mid-row
        cfg_pulse();
        shift = 2;
        load_filter('{1, -2, 3, -1, 4, -3, 2, 0, -1});
        start_phase();
        fork
            send_frame(2, 6, 0);
            begin
                repeat (32) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_idle();
        check("bp_count", got_d.size(), 24);
        check("bp_stalled", stall_seen > 0, 1);

        // start-of-frame mid-row
        start_phase();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < IMG_W; c++)
                if (r < 3 || c < 4) send_pix(pixv(2, r, c), r == 0 && c == 0, 1'b0);
        send_frame(2, 4, 10);
        wait_idle();
        check("sof_count", got_d.size(), 20);

        // reload with results still in flight
        start_phase();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < IMG_W; c++)
                send_pix(pixv(2, r, c), r == 0 && c == 0, r == 2 && c == 7);
        wait_filt();
        check("drain_pending", exp_d.size(), 0);
        check("drain_count", got_d.size(), 6);
        shift = 0;
        load_filter('{-1, 0, 1, -2, 0, 2, -1, 0, 1});
        start_phase();
        send_frame(0, 3, 0);
        wait_idle();
        check("sobel_data", gd(0), 8);
        check("sobel_flag", gs(0), 0);

        // reset in the middle of a frame
        start_phase();
        for (int p = 0; p < 20; p++)
            send_pix(pixv(0, p / IMG_W, p % IMG_W), p == 0, 1'b0);
        nRST = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("midrst");
        @(posedge clk); #1;
        nRST = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_filt_state", filt_ready, 1);
        repeat (8) @(negedge clk);
        check("midrst_no_out", got_d.size(), 0);
        check("final_queue", exp_d.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_array_stream.md
# conv_array_stream

Parametrised, stream-fed 2-D convolution engine, successor to the fixed 3x3 row-stationary PE array top. It computes a valid K x K signed convolution over a frame of IMG_W columns and unbounded rows. Ifmap pixels and filter coefficients arrive on valid/ready streams. An internal sequencer loads coefficients, runs frames and drains the pipeline. Each result is rounded, right-shifted and saturated back to DW bits, with backpressure from the consumer.

## Interface
- K, 3: kernel size; K >= 2.
- DW, 8: signed pixel, coefficient and output width.
- IMG_W, 8: frame width in pixels; IMG_W >= K.
- AW, 2*DW+$clog2(K*K): accumulator width; the sum is exact, with no internal wrap.
- SHW, 4: width of the `shift` input.
- clk, input, 1: single clock, rising edge.
- nRST, input, 1: synchronous, active-low reset.
- cfg_load, input, 1: one-cycle request to reload coefficients.
- filt_valid / filt_ready, input / output, 1 / 1: coefficient handshake.
- filt_data, input, DW: coefficient, row-major f[i][j], index i*K+j.
- pix_valid / pix_ready, input / output, 1 / 1: pixel handshake.
- pix_data, input, DW: pixel, row-major.
- pix_sof, input, 1: qualifies a pixel beat as the first pixel of a frame.
- shift, input, SHW: output right-shift amount; static during RUN.
- out_valid / out_ready, output / input, 1 / 1: result handshake.
- out_data, output, DW: saturated result.
- out_sat, output, 1: saturation occurred on the current out_data.
- busy, output, 1: high in RUN or DRAIN.

## Operation
**Reset values**
- While nRST is low: filt_ready=0, pix_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0.
- Reset clears all counters, line buffers and the pipeline. Coefficients become invalid.
- First cycle after release: state FILT.

**FILT state**
- filt_ready=1, pix_ready=0.
- Accepts exactly K*K coefficient beats, counted 0..K*K-1.
- After the last beat: move to RUN.
- pix_valid is ignored.

**RUN state**
- filt_ready=0.
- pix_ready = !(out_valid && !out_ready).
- An accepted pixel updates column counter c (0..IMG_W-1, wraps to 0 and increments r) and row counter r. It is written to K-1 internal line buffers of depth IMG_W.
- A beat with pix_sof=1 forces c=0, r=0 for that pixel and invalidates all line-buffer history.

**Result definition**
- When the accepted pixel is at (r,c) with r>=K-1 and c>=K-1, one result is produced:
  y = sum over i,j of f[i][j]*x[r-K+1+i][c-K+1+j].
- Each frame row therefore yields IMG_W-K+1 results; rows 0..K-2 yield none.

**cfg_load**
- In RUN: move to DRAIN; pix_ready=0 from the next cycle.
- In FILT: ignored.
- Simultaneous with an accepted pixel: the pixel is kept.

**DRAIN state**
- Waits until no result is in flight or pending, then moves to FILT.
- Frame position is lost; the next frame must start with pix_sof.

**Arithmetic**
- All values are two's-complement signed. Products are 2*DW bits; the accumulator is AW bits.
- If shift>0: add 1<<(shift-1), then arithmetic shift right by shift (round half up).
- Saturate to [-(2^(DW-1)), 2^(DW-1)-1]. out_sat=1 iff clamping happened.

## Timing
- Pipeline latency is LAT=K+1 advancing cycles, from the accept of the completing pixel to out_valid=1. With no stall, a result appears K+1 clocks later.
- Throughput is one pixel per clock and up to one result per clock.
- Advance enable = !(out_valid && !out_ready).
  - While out_valid=1 and out_ready=0, the whole pipeline holds.
  - out_data and out_sat hold stable; no result is lost or duplicated.
- out_valid drops in the cycle after the handshake unless a new result is ready.
- A pixel with pix_valid=1 while pix_ready=0 is not consumed; the source must hold it.
- pix_sof on a stalled beat takes effect only at the accept.
- busy rises the cycle after entering RUN and falls the cycle after leaving DRAIN.
- A reset asserted mid-frame or mid-drain has priority over everything. Outputs reach their reset values at the first clock edge with nRST low.

## Test plan
- **Identity filter:** K=3, IMG_W=8, center coefficient 1, others 0, shift=0; pixel=8r+c for r=0..4. Expect out_data = 8(r-1)+(c-1): first result 9, 6 results per row, 18 total. First out_valid 4 clocks after pixel (2,2) is accepted.
- **Positive saturation:** all coefficients 1, all pixels 127. With shift=0: out_data=127, out_sat=1. With shift=4: out_data=(1143+8)>>4=71, out_sat=0.
- **Negative saturation:** all coefficients -128, pixels 127, shift=0. Expect out_data=-128, out_sat=1.
- **Backpressure:** out_ready low for 5 cycles mid-row. Expect pix_ready=0 throughout, out_data stable, and the result stream bit-exact against the model with no gaps or duplicates.
- **pix_sof mid-frame:** pix_sof asserted at row 3, column 4. Expect no results until 2 new rows are complete, and the results computed only from post-sof pixels.
- **Reload and reset:** cfg_load during RUN, then load a new coefficient set. Expect DRAIN to flush pending results using the old filter, then FILT, then the new filter used. Then assert nRST mid-frame: all outputs return to their reset values at the next edge, and state is FILT.
